// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/parity/stop recovery with 2-of-3 majority voting.
// Good words load P_DATA with a data_valid strobe; bad frames only raise error strobes.
//
// state  | meaning
// IDLE   | line idle, waiting for a low sample
// START  | qualifying the start bit (glitch filter)
// DATA   | shifting in Data_width bits, LSB first
// PARITY | checking the optional parity bit
// STOP   | checking the stop bit, publishing word or errors
module uart_rx #(
    parameter int Data_width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [Data_width-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error
);

    localparam int BW = (Data_width > 1) ? $clog2(Data_width) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state_q, state_d;
    logic [5:0]              psc_q, psc_sel, half;
    logic                    par_en_q, par_typ_q;
    logic [5:0]              edge_cnt;
    logic [BW-1:0]           bit_cnt;
    logic [2:0]              smp_q;
    logic [Data_width-1:0]   shreg;
    logic                    par_err_q;
    logic                    start_det, bit_end, last_bit, maj, par_exp;
    logic                    dv_d, pe_d, se_d;

    // Unsupported ratios fall back to 8x oversampling.
    always_comb begin
        case (prescale)
            6'd8, 6'd16, 6'd32: psc_sel = prescale;
            default:            psc_sel = 6'd8;
        endcase
    end

    assign half      = {1'b0, psc_q[5:1]};
    assign start_det = (state_q == IDLE) && !RX_IN;
    assign bit_end   = (state_q != IDLE) && (edge_cnt == psc_q - 6'd1);
    assign last_bit  = (bit_cnt == BW'(Data_width - 1));
    assign maj       = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    assign par_exp   = par_typ_q ? ~^shreg : ^shreg;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!RX_IN) state_d = START;
            START:   if (bit_end) state_d = maj ? IDLE : DATA;
            DATA:    if (bit_end && last_bit) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dv_d = 1'b0;
        pe_d = 1'b0;
        se_d = 1'b0;
        if (state_q == STOP && bit_end) begin
            dv_d = !par_err_q && maj;
            pe_d = par_err_q;
            se_d = !maj;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            psc_q        <= 6'd0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            edge_cnt     <= 6'd0;
            bit_cnt      <= '0;
            smp_q        <= 3'b000;
            shreg        <= '0;
            par_err_q    <= 1'b0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            data_valid   <= dv_d;
            parity_error <= pe_d;
            stop_error   <= se_d;
            if (dv_d) P_DATA <= shreg;

            // The detecting edge is j = 0 of the start bit, so counting resumes at 1.
            if (start_det) begin
                psc_q     <= psc_sel;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                edge_cnt  <= 6'd1;
                bit_cnt   <= '0;
                par_err_q <= 1'b0;
                smp_q     <= 3'b111;
            end else if (state_q != IDLE) begin
                edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
                if (edge_cnt == half - 6'd1) smp_q[0] <= RX_IN;
                if (edge_cnt == half)        smp_q[1] <= RX_IN;
                if (edge_cnt == half + 6'd1) smp_q[2] <= RX_IN;
                if (bit_end) begin
                    case (state_q)
                        DATA: begin
                            shreg   <= {maj, shreg[Data_width-1:1]};
                            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                        end
                        PARITY:  par_err_q <= (maj != par_exp);
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: framing, parity, stop errors, glitch filter, back-to-back and reset.
module tb_uart_rx;

    logic       CLK_tb = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    logic [7:0] dv_data[$];
    int         dv_cyc[$];
    int         pe_cnt = 0;
    int         se_cnt = 0;

    uart_rx #(.Data_width(8)) dut (
        .CLK(CLK_tb),
        .RST(RST),
        .RX_IN(RX_IN),
        .prescale(prescale),
        .PAR_EN(PAR_EN),
        .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA),
        .data_valid(data_valid),
        .parity_error(parity_error),
        .stop_error(stop_error)
    );

    always #5 CLK_tb = ~CLK_tb;

    always @(posedge CLK_tb) cyc++;

    // Each strobe cycle seen at the falling edge is logged with the edge count it rose on.
    always @(negedge CLK_tb) begin
        if (data_valid) begin
            dv_data.push_back(P_DATA);
            dv_cyc.push_back(cyc);
        end
        if (parity_error) pe_cnt++;
        if (stop_error) se_cnt++;
    end

    task automatic drive_bit(input logic v, input int psc);
        RX_IN = v;
        repeat (psc) @(negedge CLK_tb);
    endtask

    // Called on a falling edge; the following rising edge is the start-detect edge t0.
    task automatic send_frame(input logic [7:0] d, input int psc, input logic par_en,
                              input logic par_bit, input logic stop_bit);
        prescale  = psc[5:0];
        PAR_EN    = par_en;
        start_cyc = cyc + 1;
        drive_bit(1'b0, psc);
        for (int i = 0; i < 8; i++) drive_bit(d[i], psc);
        if (par_en) drive_bit(par_bit, psc);
        drive_bit(stop_bit, psc);
        RX_IN = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b0; RX_IN = 1'b1; prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(negedge CLK_tb);
        tests++; if (P_DATA !== 8'h00) begin fails++; $display("FAIL reset_pdata: got %0h expected 00", P_DATA); end
        tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL reset_dv: got %b expected 0", data_valid); end
        tests++; if (parity_error !== 1'b0) begin fails++; $display("FAIL reset_pe: got %b expected 0", parity_error); end
        tests++; if (stop_error !== 1'b0) begin fails++; $display("FAIL reset_se: got %b expected 0", stop_error); end
        RST = 1'b1;
        repeat (3) @(negedge CLK_tb);
    endtask

    task automatic test_8n1();
        int n0 = dv_data.size(); int p0 = pe_cnt; int s0 = se_cnt;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge CLK_tb);
        tests++; if (dv_data.size() - n0 != 1) begin fails++; $display("FAIL 8n1_dv_count: got %0d expected 1", dv_data.size() - n0); end
        tests++; if (P_DATA !== 8'hA5) begin fails++; $display("FAIL 8n1_pdata: got %0h expected a5", P_DATA); end
        tests++; if (dv_data.size() == n0 || dv_cyc[$] - start_cyc != 79) begin fails++; $display("FAIL 8n1_latency: got %0d expected 79", (dv_data.size() == n0) ? -1 : dv_cyc[$] - start_cyc); end
        tests++; if (pe_cnt != p0 || se_cnt != s0) begin fails++; $display("FAIL 8n1_errors: got pe %0d se %0d expected 0 0", pe_cnt - p0, se_cnt - s0); end
    endtask

    task automatic test_parity();
        int n0, p0;
        PAR_TYP = 1'b0;
        n0 = dv_data.size();
        send_frame(8'h48, 8, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge CLK_tb);
        tests++; if (dv_data.size() - n0 != 1) begin fails++; $display("FAIL even_ok_dv: got %0d expected 1", dv_data.size() - n0); end
        tests++; if (P_DATA !== 8'h48) begin fails++; $display("FAIL even_ok_pdata: got %0h expected 48", P_DATA); end
        tests++; if (dv_data.size() == n0 || dv_cyc[$] - start_cyc != 87) begin fails++; $display("FAIL even_ok_latency: got %0d expected 87", (dv_data.size() == n0) ? -1 : dv_cyc[$] - start_cyc); end

        n0 = dv_data.size(); p0 = pe_cnt;
        send_frame(8'h48, 8, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge CLK_tb);
        tests++; if (pe_cnt - p0 != 1) begin fails++; $display("FAIL even_bad_pe: got %0d expected 1", pe_cnt - p0); end
        tests++; if (dv_data.size() != n0) begin fails++; $display("FAIL even_bad_dv: got %0d expected 0", dv_data.size() - n0); end
        tests++; if (P_DATA !== 8'h48) begin fails++; $display("FAIL even_bad_pdata: got %0h expected 48", P_DATA); end

        PAR_TYP = 1'b1;
        n0 = dv_data.size(); p0 = pe_cnt;
        send_frame(8'h48, 8, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge CLK_tb);
        tests++; if (dv_data.size() - n0 != 1 || pe_cnt != p0) begin fails++; $display("FAIL odd_ok: got dv %0d pe %0d expected 1 0", dv_data.size() - n0, pe_cnt - p0); end
        tests++; if (dv_data.size() == n0 || dv_data[$] !== 8'h48) begin fails++; $display("FAIL odd_ok_pdata: got %0h expected 48", P_DATA); end
        PAR_TYP = 1'b0;
    endtask

    task automatic test_stop_error();
        int n0 = dv_data.size(); int p0 = pe_cnt; int s0 = se_cnt;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge CLK_tb);
        tests++; if (se_cnt - s0 != 1) begin fails++; $display("FAIL stop_se: got %0d expected 1", se_cnt - s0); end
        tests++; if (dv_data.size() != n0) begin fails++; $display("FAIL stop_dv: got %0d expected 0", dv_data.size() - n0); end
        tests++; if (P_DATA !== 8'h48) begin fails++; $display("FAIL stop_pdata: got %0h expected 48", P_DATA); end
        tests++; if (pe_cnt != p0) begin fails++; $display("FAIL stop_pe: got %0d expected 0", pe_cnt - p0); end
    endtask

    task automatic test_back_to_back();
        int n0 = dv_data.size(); int p0 = pe_cnt; int s0 = se_cnt; int t_first;
        prescale = 6'd16; PAR_EN = 1'b0;
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK_tb);
        RX_IN = 1'b1;
        repeat (30) @(negedge CLK_tb);
        tests++; if (dv_data.size() != n0 || pe_cnt != p0 || se_cnt != s0) begin fails++; $display("FAIL glitch_quiet: got dv %0d pe %0d se %0d expected 0 0 0", dv_data.size() - n0, pe_cnt - p0, se_cnt - s0); end

        send_frame(8'h00, 16, 1'b0, 1'b0, 1'b1);
        t_first = start_cyc;
        send_frame(8'hFF, 16, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge CLK_tb);
        tests++; if (dv_data.size() - n0 != 2) begin fails++; $display("FAIL b2b_count: got %0d expected 2", dv_data.size() - n0); end
        else begin
            tests++; if (dv_data[n0] !== 8'h00) begin fails++; $display("FAIL b2b_first: got %0h expected 00", dv_data[n0]); end
            tests++; if (dv_data[n0+1] !== 8'hFF) begin fails++; $display("FAIL b2b_second: got %0h expected ff", dv_data[n0+1]); end
            tests++; if (dv_cyc[n0+1] - dv_cyc[n0] != 160) begin fails++; $display("FAIL b2b_gap: got %0d expected 160", dv_cyc[n0+1] - dv_cyc[n0]); end
            tests++; if (dv_cyc[n0] - t_first != 159) begin fails++; $display("FAIL b2b_latency: got %0d expected 159", dv_cyc[n0] - t_first); end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d = 8'hC3;
        int n0;
        prescale = 6'd8; PAR_EN = 1'b0;
        drive_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 8);
        RX_IN = d[4];
        repeat (3) @(negedge CLK_tb);
        RST = 1'b0;
        #1;
        tests++; if (P_DATA !== 8'h00 || data_valid !== 1'b0 || parity_error !== 1'b0 || stop_error !== 1'b0) begin
            fails++; $display("FAIL midreset_outputs: got %0h %b %b %b expected 00 0 0 0", P_DATA, data_valid, parity_error, stop_error);
        end
        n0 = dv_data.size();
        repeat (5) @(negedge CLK_tb);
        RX_IN = 1'b1;
        RST = 1'b1;
        repeat (100) @(negedge CLK_tb);
        tests++; if (dv_data.size() != n0) begin fails++; $display("FAIL midreset_no_strobe: got %0d expected 0", dv_data.size() - n0); end

        send_frame(8'h5A, 32, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge CLK_tb);
        tests++; if (dv_data.size() - n0 != 1 || P_DATA !== 8'h5A) begin fails++; $display("FAIL midreset_recover: got %0h count %0d expected 5a count 1", P_DATA, dv_data.size() - n0); end
        tests++; if (dv_data.size() == n0 || dv_cyc[$] - start_cyc != 319) begin fails++; $display("FAIL midreset_latency: got %0d expected 319", (dv_data.size() == n0) ? -1 : dv_cyc[$] - start_cyc); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_stop_error();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
